// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: derives per-register
// enable/flush, PC enable and data-memory enable, plus halt and stall statistics.
module pipe_hazard_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              mem_dREN,
    input  logic              mem_dWEN,
    input  logic              idex_dREN,
    input  logic [4:0]        idex_rt,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              branch_taken,
    input  logic              jmp_id,
    input  logic              wb_halt,
    output logic              en_ifid,
    output logic              fl_ifid,
    output logic              en_idex,
    output logic              fl_idex,
    output logic              en_exmem,
    output logic              fl_exmem,
    output logic              en_memwb,
    output logic              fl_memwb,
    output logic              pc_en,
    output logic              dmem_en,
    output logic              halt,
    output logic [DATA_W-1:0] stall_cnt,
    output logic [DATA_W-1:0] lu_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_stall_cnt;
    logic [DATA_W-1:0] r_lu_cnt;

    logic w_halt_now;
    logic w_dmem_en;
    logic w_memreq;
    logic w_adv;
    logic w_lu;
    logic w_lu_apply;
    logic w_stall_inc;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Hazard detection: everything here is same-cycle combinational.
    assign w_halt_now  = (r_state == HALT) | wb_halt;
    assign w_dmem_en   = ~w_halt_now;
    assign w_memreq    = (mem_dREN | mem_dWEN) & w_dmem_en;
    assign w_adv       = ~w_memreq | dhit;
    assign w_lu        = idex_dREN & (idex_rt != 5'd0) &
                         ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
    assign w_lu_apply  = ~w_halt_now & w_adv & ~branch_taken & w_lu;
    assign w_stall_inc = w_memreq & ~dhit & (r_state != HALT);

    always_comb begin
        w_state_nxt = r_state;
        if (wb_halt) begin
            w_state_nxt = HALT;
        end else begin
            case (r_state)
                RUN:     if (w_memreq && !dhit) w_state_nxt = DWAIT;
                DWAIT:   if (dhit) w_state_nxt = RUN;
                HALT:    w_state_nxt = HALT;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall_inc) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_lu_apply)  r_lu_cnt    <= sat_inc(r_lu_cnt);
        end
    end

    // Highest-priority condition wins; halt and data stall freeze everything.
    always_comb begin
        en_ifid  = 1'b0;
        fl_ifid  = 1'b0;
        en_idex  = 1'b0;
        fl_idex  = 1'b0;
        en_exmem = 1'b0;
        fl_exmem = 1'b0;
        en_memwb = 1'b0;
        fl_memwb = 1'b0;
        pc_en    = 1'b0;
        dmem_en  = w_dmem_en;
        if (w_halt_now || !w_adv) begin
            pc_en = 1'b0;
        end else if (branch_taken) begin
            en_ifid  = 1'b1;
            en_idex  = 1'b1;
            en_exmem = 1'b1;
            en_memwb = 1'b1;
            fl_ifid  = 1'b1;
            fl_idex  = 1'b1;
            fl_exmem = 1'b1;
            pc_en    = 1'b1;
        end else if (w_lu) begin
            // Hold IF/ID and PC, inject a bubble into ID/EX.
            en_idex  = 1'b1;
            fl_idex  = 1'b1;
            en_exmem = 1'b1;
            en_memwb = 1'b1;
        end else if (jmp_id) begin
            en_ifid  = 1'b1;
            en_idex  = 1'b1;
            en_exmem = 1'b1;
            en_memwb = 1'b1;
            fl_ifid  = 1'b1;
            pc_en    = 1'b1;
        end else if (!ihit) begin
            en_ifid  = 1'b1;
            en_idex  = 1'b1;
            en_exmem = 1'b1;
            en_memwb = 1'b1;
            fl_ifid  = 1'b1;
        end else begin
            en_ifid  = 1'b1;
            en_idex  = 1'b1;
            en_exmem = 1'b1;
            en_memwb = 1'b1;
            pc_en    = 1'b1;
        end
    end

    assign halt      = (r_state == HALT);
    assign stall_cnt = r_stall_cnt;
    assign lu_cnt    = r_lu_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard priority, stalls, halt, reset, saturation.
module tb_pipe_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, idex_dREN;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        ifid_uses_rt, branch_taken, jmp_id, wb_halt;
    logic        en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem;
    logic        en_memwb, fl_memwb, pc_en, dmem_en, halt;
    logic [15:0] stall_cnt, lu_cnt;
    logic [10:0] obs;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_lu    = 0;

    // {en_ifid,fl_ifid,en_idex,fl_idex,en_exmem,fl_exmem,en_memwb,fl_memwb,pc_en,dmem_en,halt}
    localparam logic [10:0] V_NORMAL = 11'b10101010110;
    localparam logic [10:0] V_LU     = 11'b00111010010;
    localparam logic [10:0] V_JMP    = 11'b11101010110;
    localparam logic [10:0] V_IMISS  = 11'b11101010010;
    localparam logic [10:0] V_BRANCH = 11'b11111110110;
    localparam logic [10:0] V_STALL  = 11'b00000000010;
    localparam logic [10:0] V_HALTIN = 11'b00000000000;
    localparam logic [10:0] V_HALTED = 11'b00000000001;

    always #5 CLK = ~CLK;

    assign obs = {en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem,
                  en_memwb, fl_memwb, pc_en, dmem_en, halt};

    pipe_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .idex_dREN(idex_dREN),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
        .jmp_id(jmp_id), .wb_halt(wb_halt),
        .en_ifid(en_ifid), .fl_ifid(fl_ifid), .en_idex(en_idex), .fl_idex(fl_idex),
        .en_exmem(en_exmem), .fl_exmem(fl_exmem), .en_memwb(en_memwb),
        .fl_memwb(fl_memwb), .pc_en(pc_en), .dmem_en(dmem_en), .halt(halt),
        .stall_cnt(stall_cnt), .lu_cnt(lu_cnt)
    );

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        idex_dREN = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ifid_uses_rt = 1'b0; branch_taken = 1'b0; jmp_id = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        tick(); tick();
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL reset_outputs got=%b want=%b", obs, V_NORMAL); end
        total++;
        if (stall_cnt !== 16'd0 || lu_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, lu_cnt);
        end
        #3 nRST = 1'b1;
        tick();
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL first_run got=%b want=%b", obs, V_NORMAL); end
        exp_stall = 0; exp_lu = 0;
    endtask

    task automatic test_load_use();
        idle_inputs();
        idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        #1;
        total++;
        if (obs !== V_LU) begin bad++; $display("FAIL lu_rs got=%b want=%b", obs, V_LU); end
        tick(); exp_lu++;
        total++;
        if (lu_cnt !== 16'(exp_lu)) begin bad++; $display("FAIL lu_cnt_inc got=%0d want=%0d", lu_cnt, exp_lu); end
        // rt match only counts when the ID instruction reads rt
        ifid_rs = 5'd1; ifid_rt = 5'd5; ifid_uses_rt = 1'b0;
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL lu_rt_unused got=%b want=%b", obs, V_NORMAL); end
        ifid_uses_rt = 1'b1;
        #1;
        total++;
        if (obs !== V_LU) begin bad++; $display("FAIL lu_rt_used got=%b want=%b", obs, V_LU); end
        tick(); exp_lu++;
        total++;
        if (lu_cnt !== 16'(exp_lu)) begin bad++; $display("FAIL lu_cnt_rt got=%0d want=%0d", lu_cnt, exp_lu); end
    endtask

    task automatic test_lu_zero();
        idle_inputs();
        idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL lu_zero got=%b want=%b", obs, V_NORMAL); end
        tick();
        total++;
        if (lu_cnt !== 16'(exp_lu)) begin bad++; $display("FAIL lu_zero_cnt got=%0d want=%0d", lu_cnt, exp_lu); end
    endtask

    task automatic test_jmp_imiss();
        idle_inputs();
        jmp_id = 1'b1;
        #1;
        total++;
        if (obs !== V_JMP) begin bad++; $display("FAIL jmp got=%b want=%b", obs, V_JMP); end
        ihit = 1'b0;
        #1;
        total++;
        if (obs !== V_JMP) begin bad++; $display("FAIL jmp_over_imiss got=%b want=%b", obs, V_JMP); end
        jmp_id = 1'b0;
        #1;
        total++;
        if (obs !== V_IMISS) begin bad++; $display("FAIL imiss got=%b want=%b", obs, V_IMISS); end
        jmp_id = 1'b1; idex_dREN = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9;
        #1;
        total++;
        if (obs !== V_LU) begin bad++; $display("FAIL lu_over_jmp got=%b want=%b", obs, V_LU); end
        tick(); exp_lu++;
    endtask

    task automatic test_branch_lu();
        idle_inputs();
        branch_taken = 1'b1; jmp_id = 1'b1;
        idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
        #1;
        total++;
        if (obs !== V_BRANCH) begin bad++; $display("FAIL branch_lu got=%b want=%b", obs, V_BRANCH); end
        tick();
        total++;
        if (lu_cnt !== 16'(exp_lu)) begin bad++; $display("FAIL branch_lu_cnt got=%0d want=%0d", lu_cnt, exp_lu); end
        // a pending data access outranks the branch squash
        mem_dWEN = 1'b1; dhit = 1'b0;
        #1;
        total++;
        if (obs !== V_STALL) begin bad++; $display("FAIL stall_over_branch got=%b want=%b", obs, V_STALL); end
        dhit = 1'b1;
        #1;
        total++;
        if (obs !== V_BRANCH) begin bad++; $display("FAIL branch_dhit got=%b want=%b", obs, V_BRANCH); end
        tick();
    endtask

    task automatic test_data_stall();
        idle_inputs();
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (obs !== V_STALL) begin bad++; $display("FAIL dstall_%0d got=%b want=%b", i, obs, V_STALL); end
            tick(); exp_stall++;
        end
        total++;
        if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL stall_cnt3 got=%0d want=%0d", stall_cnt, exp_stall); end
        dhit = 1'b1;
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL dhit_release got=%b want=%b", obs, V_NORMAL); end
        tick();
        total++;
        if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL stall_cnt_hit got=%0d want=%0d", stall_cnt, exp_stall); end
        mem_dREN = 1'b0; dhit = 1'b0;
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL after_stall got=%b want=%b", obs, V_NORMAL); end
        tick();
    endtask

    task automatic test_halt();
        idle_inputs();
        wb_halt = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
        #1;
        total++;
        if (obs !== V_HALTIN) begin bad++; $display("FAIL halt_in got=%b want=%b", obs, V_HALTIN); end
        tick();
        total++;
        if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL halt_stallcnt got=%0d want=%0d", stall_cnt, exp_stall); end
        wb_halt = 1'b0;
        idex_dREN = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if (obs !== V_HALTED) begin bad++; $display("FAIL halted_%0d got=%b want=%b", i, obs, V_HALTED); end
            tick();
        end
        total++;
        if (lu_cnt !== 16'(exp_lu) || stall_cnt !== 16'(exp_stall)) begin
            bad++; $display("FAIL halt_cnts got=%0d/%0d want=%0d/%0d", stall_cnt, lu_cnt, exp_stall, exp_lu);
        end
        idle_inputs();
        #2 nRST = 1'b0;
        #1;
        total++;
        if (obs !== V_NORMAL || stall_cnt !== 16'd0 || lu_cnt !== 16'd0) begin
            bad++; $display("FAIL halt_reset got=%b/%0d/%0d want=%b/0/0", obs, stall_cnt, lu_cnt, V_NORMAL);
        end
        #1 nRST = 1'b1;
        exp_stall = 0; exp_lu = 0;
        tick();
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL post_halt_run got=%b want=%b", obs, V_NORMAL); end
    endtask

    task automatic test_reset_mid_dwait();
        idle_inputs();
        mem_dREN = 1'b1;
        tick(); tick();
        #1 nRST = 1'b0;
        #1;
        total++;
        if (stall_cnt !== 16'd0) begin bad++; $display("FAIL dwait_reset_cnt got=%0d want=0", stall_cnt); end
        mem_dREN = 1'b0;
        #1 nRST = 1'b1;
        tick();
        #1;
        total++;
        if (obs !== V_NORMAL) begin bad++; $display("FAIL dwait_reset_run got=%b want=%b", obs, V_NORMAL); end
    endtask

    task automatic test_saturation();
        idle_inputs();
        mem_dREN = 1'b1; dhit = 1'b0;
        repeat (65534) tick();
        total++;
        if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", stall_cnt); end
        tick();
        total++;
        if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h want=ffff", stall_cnt); end
        repeat (4465) tick();
        total++;
        if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", stall_cnt); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lu_zero();
        test_jmp_imiss();
        test_branch_lu();
        test_data_stall();
        test_halt();
        test_reset_mid_dwait();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have these ports: CLK in 1, rising-edge clock; nRST in 1, asynchronous active-low reset.
REQ-002 The block SHALL have these inputs: ihit 1, instruction fetch complete; dhit 1, data access complete; mem_dREN 1 and mem_dWEN 1, read/write request from EX/MEM register output; idex_dREN 1, load in EX stage; idex_rt 5, load destination; ifid_rs 5, ID-stage source; ifid_rt 5, ID-stage source; ifid_uses_rt 1, ID instruction reads rt; branch_taken 1, branch resolved taken in MEM; jmp_id 1, jump/jal/jr decoded in ID; wb_halt 1, halt in MEM/WB output.
REQ-003 The block SHALL have these outputs, each 1 bit: en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem, en_memwb, fl_memwb, pc_en, dmem_en, halt.
REQ-004 The block SHALL have two further outputs: stall_cnt 16, saturating count of data-stall cycles; lu_cnt 16, saturating count of load-use bubbles.
REQ-005 Each fl_* output SHALL have priority over the matching en_* output inside the pipeline register.

Function
REQ-006 The block SHALL use FSM states RUN, DWAIT and HALT, held in a registered state variable.
REQ-007 The block SHALL define memreq = (mem_dREN | mem_dWEN) & dmem_en.
REQ-008 The block SHALL define adv = !memreq | dhit, meaning the downstream stages may advance.
REQ-009 The block SHALL define lu = idex_dREN & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt))).
REQ-010 Output priority per cycle SHALL be, highest first: halt, data stall, branch_taken, load-use, jmp_id, !ihit, normal.
REQ-011 Halt (state HALT or wb_halt=1): all en_*, fl_*, pc_en and dmem_en SHALL be 0.
REQ-012 Data stall (adv=0, not halt): all en_*, fl_* and pc_en SHALL be 0.
REQ-013 The same-cycle dhit SHALL release a data stall (zero added latency).
REQ-014 branch_taken with adv=1: all en_* SHALL be 1, fl_ifid=fl_idex=fl_exmem=1, fl_memwb=0, pc_en=1.
REQ-015 A branch_taken squash SHALL override load-use and jmp_id in the same cycle.
REQ-016 Load-use with adv=1: en_ifid=0, pc_en=0, en_idex=1, fl_idex=1 (bubble), en_exmem=en_memwb=1, remaining fl_* 0.
REQ-017 jmp_id with adv=1 and no lu: all en_* SHALL be 1, fl_ifid=1, pc_en=1.
REQ-018 !ihit with adv=1 and no branch/lu/jmp: all en_* SHALL be 1, fl_ifid=1 (bubble), pc_en=0.
REQ-019 Normal (adv=1, ihit=1, no hazard): all en_* SHALL be 1, all fl_* 0, pc_en=1.
REQ-020 dmem_en SHALL be 1 in RUN and DWAIT when wb_halt=0.
REQ-021 halt SHALL be 1 only in state HALT, i.e. registered and asserted one cycle after wb_halt is first seen.
REQ-022 FSM transitions SHALL be: any state with wb_halt=1 -> HALT.
REQ-023 RUN with memreq & !dhit SHALL go to DWAIT.
REQ-024 DWAIT with dhit SHALL go to RUN.
REQ-025 DWAIT with !dhit SHALL stay in DWAIT.
REQ-026 HALT SHALL be sticky until nRST.
REQ-027 stall_cnt SHALL increment by 1 each clock where memreq & !dhit and the state is not HALT, saturating at 16'hFFFF.
REQ-028 lu_cnt SHALL increment by 1 each clock where the load-use rule (REQ-016) is applied, saturating at 16'hFFFF.
REQ-029 Outputs other than halt, stall_cnt and lu_cnt SHALL be combinational from state and inputs, with no added latency.

Reset
REQ-030 While nRST=0: state=RUN, halt=0, stall_cnt=0, lu_cnt=0.
REQ-031 While nRST=0, combinational outputs SHALL follow RUN-state rules.
REQ-032 Reset asserted mid-DWAIT or in HALT SHALL return the block to RUN on the next evaluation, with counters cleared.
REQ-033 The first clock after nRST rises SHALL obey RUN rules.

Verification
REQ-034 Load-use: idex_dREN=1, idex_rt=5, ifid_rs=5, ihit=1, no memreq -> en_ifid=0, pc_en=0, fl_idex=1, en_exmem=1, lu_cnt 0->1.
REQ-035 Load-use on $zero: idex_rt=0, ifid_rs=0 -> no bubble, all en_*=1, pc_en=1, lu_cnt unchanged.
REQ-036 Data stall: mem_dREN=1, dhit=0 for 3 cycles then dhit=1 -> all en_*=0 for 3 cycles, state DWAIT, stall_cnt=3; dhit cycle: all en_*=1, state RUN next.
REQ-037 Branch plus load-use: branch_taken=1 and lu true, adv=1 -> fl_ifid=fl_idex=fl_exmem=1, pc_en=1, lu_cnt unchanged.
REQ-038 Halt: wb_halt=1 with mem_dREN=1 -> dmem_en=0, all en_*=0 that cycle; next cycle halt=1 held for 10 cycles; nRST pulse -> halt=0, state RUN.
REQ-039 Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF and does not wrap.
